// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stall and flush controls for PC, F/D and D/X latches,
// plus a saturating count of cycles in which the PC is held.
module hazard_ctrl #(
    parameter int REG_BITS   = 3,
    parameter int BR_PENALTY = 2,   // legal 1..7
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_BITS-1:0] rsD,
    input  logic [REG_BITS-1:0] rtD,
    input  logic                rsValidD,
    input  logic                rtValidD,
    input  logic                haltD,
    input  logic                memReadX,
    input  logic [REG_BITS-1:0] writeRegX,
    input  logic                branchTakenX,
    input  logic                imemStall,
    input  logic                dmemStall,
    output logic                stallF,
    output logic                stallD,
    output logic                flushD,
    output logic                stallX,
    output logic                flushX,
    output logic                halted,
    output logic [CNT_BITS-1:0] stallCnt
);

    // state  | meaning
    // RUN    | normal issue, hazards resolved by priority
    // FLUSH  | wrong-path instructions still arriving in Decode after a taken branch
    // HALT   | HALT retired; fetch frozen until reset
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [2:0] BR_RELOAD = 3'(BR_PENALTY - 1);

    state_e              state_q, state_d;
    logic [2:0]          br_cnt_q, br_cnt_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic                load_use;

    assign load_use = memReadX &
                      ((rsValidD & (rsD == writeRegX)) | (rtValidD & (rtD == writeRegX)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            br_cnt_q    <= 3'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            br_cnt_q    <= br_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        br_cnt_d = br_cnt_q;
        case (state_q)
            S_RUN: begin
                if (dmemStall) begin
                    state_d = S_RUN;
                end else if (branchTakenX) begin
                    if (BR_PENALTY > 1) begin
                        state_d  = S_FLUSH;
                        br_cnt_d = BR_RELOAD;
                    end
                end else if (load_use) begin
                    state_d = S_RUN;
                end else if (haltD) begin
                    state_d = S_HALT;
                end
            end
            S_FLUSH: begin
                if (dmemStall) begin
                    state_d = S_FLUSH;
                end else if (branchTakenX) begin
                    br_cnt_d = BR_RELOAD;
                end else begin
                    br_cnt_d = br_cnt_q - 3'd1;
                    if (br_cnt_q <= 3'd1) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d  = S_RUN;
                br_cnt_d = 3'd0;
            end
        endcase
    end

    // Output logic; everything is quiet while reset is asserted
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        stallX = 1'b0;
        flushX = 1'b0;
        halted = 1'b0;
        if (!rst) begin
            case (state_q)
                S_RUN: begin
                    if (dmemStall) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallX = 1'b1;
                    end else if (branchTakenX) begin
                        flushD = 1'b1;
                        flushX = 1'b1;
                    end else if (load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushX = 1'b1;
                    end else if (haltD) begin
                        stallF = 1'b1;
                        flushD = 1'b1;
                    end else if (imemStall) begin
                        stallF = 1'b1;
                        flushD = 1'b1;
                    end
                end
                S_FLUSH: begin
                    // Decode holds wrong-path work, so load-use and halt are not acted on
                    if (dmemStall) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        stallX = 1'b1;
                    end else if (branchTakenX) begin
                        flushD = 1'b1;
                        flushX = 1'b1;
                    end else begin
                        flushD = 1'b1;
                        stallF = imemStall;
                    end
                end
                S_HALT: begin
                    stallF = 1'b1;
                    flushD = 1'b1;
                    halted = 1'b1;
                    stallD = dmemStall;
                    stallX = dmemStall;
                end
                default: begin
                    stallF = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != {CNT_BITS{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stallCnt = stall_cnt_q;

endmodule
